// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Recovers each byte from the serial line and presents it as a one-cycle
// rx_valid pulse together with parity and framing status.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_meta;
    logic             rxs;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       sh;
    logic             par;
    logic             perr;
    logic             half_tick;
    logic             bit_tick;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; every sampling decision happens on a counter tick.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rxs) state_nxt = S_START;
            end
            S_START: begin
                if (half_tick) state_nxt = rxs ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (bit_tick && idx == 3'd7) state_nxt = PARITY_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (bit_tick) state_nxt = S_STOP;
            end
            S_STOP: begin
                // A low stop bit must see the line return high before the
                // next start can be recognised.
                if (bit_tick) state_nxt = rxs ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (rxs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-derived outputs and sampling strobes.
    always_comb begin
        rx_busy   = (state != S_IDLE);
        half_tick = (state == S_START) && (cnt == HALF_LAST);
        bit_tick  = (cnt == FULL_LAST);
    end

    // Bit timing, bit index and delivery of the recovered byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_START: begin
                    cnt <= half_tick ? '0 : cnt + 1'b1;
                    idx <= '0;
                end
                S_DATA, S_PARITY: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (state == S_DATA) idx <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt        <= '0;
                        rx_valid   <= 1'b1;
                        rx_data    <= sh;
                        parity_err <= PARITY_EN ? perr : 1'b0;
                        frame_err  <= ~rxs;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Data shift register and running even parity; no reset needed.
    always_ff @(posedge clk) begin
        case (state)
            S_START: begin
                if (half_tick) begin
                    par  <= 1'b0;
                    perr <= 1'b0;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    sh  <= {rxs, sh[7:1]};
                    par <= par ^ rxs;
                end
            end
            S_PARITY: begin
                if (bit_tick) perr <= par ^ rxs;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames from the test plan followed by randomized
// frames, checked against a frame-level model of the receiver.
module tb_uart_rx;

    localparam int C    = 16;
    localparam int P    = 1;
    localparam int HALF = C / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    uart_rx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int   cyc   = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    int         last_valid_cyc = 0;
    int         frame_start = 0;
    logic [7:0] last_d  = 8'h00;
    logic       last_pe = 1'b0;
    logic       last_fe = 1'b0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level model: each frame sent is expected once, at its due cycle,
    // with flags derived from the bits actually put on the line.
    always @(negedge clk) begin
        if (rst_q) begin
            check("reset_rx_valid", rx_valid, 0);
            check("reset_rx_data", rx_data, 0);
            check("reset_flags", {parity_err, frame_err}, 0);
            check("reset_busy", rx_busy, 0);
            q.delete();
            last_d = 8'h00; last_pe = 1'b0; last_fe = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (rx_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
                check("valid_width", prev_valid, 0);
                check("pending_frame", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("rx_data", rx_data, e.d);
                    check("parity_err", parity_err, e.pe);
                    check("frame_err", frame_err, e.fe);
                    check("latency_window", int'(cyc >= e.due - 1 && cyc <= e.due + 1), 1);
                    last_d = e.d; last_pe = e.pe; last_fe = e.fe;
                end
            end else begin
                check("rx_data_hold", rx_data, last_d);
                check("flags_hold", {parity_err, frame_err}, {last_pe, last_fe});
                if (q.size() != 0 && cyc > q[0].due + 1) begin
                    check("frame_missing", cyc, q[0].due);
                    void'(q.pop_front());
                end
            end
            prev_valid = rx_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; optionally pulse rst for a cycle in the middle of
    // data bit abort_bit (use -1 for no abort).
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int abort_bit);
        exp_t e;
        e.d   = d;
        e.pe  = (P != 0) ? ((^d) != pbit) : 1'b0;
        e.fe  = ~stop;
        e.due = cyc + 3 + HALF + (9 + P) * C;
        frame_start = cyc;
        q.push_back(e);
        rxd = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (i == abort_bit) begin
                tick(C / 2);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                tick(C - C / 2 - 1);
            end else begin
                tick(C);
            end
        end
        if (P != 0) begin
            rxd = pbit;
            tick(C);
        end
        rxd = stop;
        tick(C);
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic pe, input logic fe);
        check({name, "_data"}, rx_data, d);
        check({name, "_perr"}, parity_err, pe);
        check({name, "_ferr"}, frame_err, fe);
    endtask

    initial begin
        int nv;
        int lat;
        logic [7:0] d;
        logic pbit;
        logic stop;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        check("idle_busy", rx_busy, 0);

        // 0xA5, correct parity 0, good stop.
        nv = n_valid;
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        rxd = 1'b1;
        tick(4);
        check("a5_count", n_valid - nv, 1);
        expect_out("a5", 8'hA5, 1'b0, 1'b0);
        lat = last_valid_cyc - frame_start;
        check("a5_latency_171", int'(lat >= 170 && lat <= 172), 1);
        check("a5_busy_after", rx_busy, 0);

        // 0x07 with wrong parity bit.
        send_frame(8'h07, 1'b0, 1'b1, -1);
        tick(4);
        expect_out("x07", 8'h07, 1'b1, 1'b0);

        // 0x3C with a low stop bit and the line held low afterwards.
        nv = n_valid;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        tick(40);
        check("x3c_wait_high_busy", rx_busy, 1);
        expect_out("x3c", 8'h3C, 1'b0, 1'b1);
        rxd = 1'b1;
        tick(4);
        check("x3c_busy_released", rx_busy, 0);
        tick(C);
        check("x3c_single_frame", n_valid - nv, 1);

        // Short low glitch on an idle line.
        nv = n_valid;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        check("glitch_busy_high", rx_busy, 1);
        tick(HALF + 3 - 4);
        check("glitch_busy_low", rx_busy, 0);
        tick(C);
        check("glitch_no_valid", n_valid - nv, 0);

        // Three back-to-back frames without idle gap.
        nv = n_valid;
        send_frame(8'h00, 1'b0, 1'b1, -1);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        send_frame(8'h55, 1'b0, 1'b1, -1);
        tick(4);
        check("b2b_count", n_valid - nv, 3);
        expect_out("b2b_last", 8'h55, 1'b0, 1'b0);

        // Reset during data bit 4, then a clean 0x81.
        nv = n_valid;
        send_frame(8'hF1, 1'b1, 1'b1, 4);
        tick(2 * C);
        check("abort_no_valid", n_valid - nv, 0);
        send_frame(8'h81, 1'b0, 1'b1, -1);
        tick(4);
        check("abort_next_count", n_valid - nv, 1);
        expect_out("x81", 8'h81, 1'b0, 1'b0);

        // Transmitter-style loopback frame.
        send_frame(8'h12, 1'b0, 1'b1, -1);
        tick(4);
        expect_out("loop", 8'h12, 1'b0, 1'b0);

        // Randomized traffic: parity and stop errors, gaps, glitches.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                rxd = 1'b0;
                tick($urandom_range(1, HALF - 2));
                rxd = 1'b1;
                tick(HALF + 4);
            end
            d    = 8'($urandom);
            pbit = ^d;
            if ($urandom_range(0, 7) == 0) pbit = ~pbit;
            stop = ($urandom_range(0, 9) != 0);
            send_frame(d, pbit, stop, -1);
            if (!stop) begin
                tick($urandom_range(0, 30));
                rxd = 1'b1;
                tick($urandom_range(2, 6));
            end else begin
                rxd = 1'b1;
                tick($urandom_range(0, 2) * $urandom_range(0, C));
            end
        end

        rxd = 1'b1;
        tick(2 * C);
        check("frames_outstanding", q.size(), 0);
        check("final_busy", rx_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver paired with the team's UART transmitter. It consumes the transmitter's serial line and recovers the bytes. Frame format, LSB first:
- 1 start bit (0)
- 8 data bits
- 1 even-parity bit (optional)
- 1 stop bit (1)

Each recovered byte is presented as a one-cycle valid pulse with status flags to the downstream byte consumer.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 4..65535.
PARITY_EN, 1, 1 = parity bit expected between data and stop; 0 = no parity bit.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
rxd  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  last received byte, held until the next byte is delivered
rx_valid  output  1  one-cycle pulse, rx_data/parity_err/frame_err valid
parity_err  output  1  parity mismatch on delivered byte; valid with rx_valid
frame_err  output  1  stop bit sampled 0 on delivered byte; valid with rx_valid
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values, all synchronous with rst high at clk edge:
  - rx_data=8'h00, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - State=IDLE; synchronizer flops = 1.
- Input conditioning: rxd passes through a 2-flop synchronizer (rxs). All logic uses rxs only; rxd→rxs latency is 2 cycles.
- Bit counter: cnt, width clog2(CLKS_PER_BIT); bit index idx, 3 bits; shift register sh, 8 bits; running parity par.
- State machine, one-hot or encoded (implementer's choice):
  - IDLE: when rxs==0 → START, cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (integer divide), then sample rxs at mid-bit.
    - rxs==1 → false start (glitch): back to IDLE, nothing delivered.
    - rxs==0 → DATA, cnt=0, idx=0, par=0.
  - DATA: every CLKS_PER_BIT cycles (cnt wraps at CLKS_PER_BIT-1), sample rxs.
    - Shift into sh MSB side; sh shifts right, so the first bit ends in sh[0].
    - par ^= sample.
    - After idx==7 sample → PARITY if PARITY_EN else STOP.
  - PARITY: sample after CLKS_PER_BIT cycles; perr = par ^ sample (even parity: data ones + parity bit is even) → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - On the edge after the sample: rx_data<=sh, rx_valid<=1, parity_err<=perr (0 if !PARITY_EN), frame_err<=~sample.
    - sample==1 → IDLE; sample==0 → WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then → IDLE. This prevents a break or frame error from re-triggering a start on the same low level.
- Latency: rx_valid rises exactly 1 cycle after the mid-stop-bit sample edge. From the start bit's falling edge on rxd, that is 2 + CLKS_PER_BIT/2 + (8+PARITY_EN+1)*CLKS_PER_BIT + 1 cycles, ±1 for asynchronous edge alignment.
- Output timing:
  - rx_valid is high for exactly 1 cycle per frame.
  - parity_err and frame_err hold their values until the next rx_valid.
- Back-to-back frames:
  - A new start bit immediately after the stop bit is accepted. IDLE is entered mid-stop-bit, so the next falling edge is detected.
  - No idle gap is required.
- Reset mid-frame: the frame is abandoned, with no rx_valid. The receiver returns to IDLE and waits for the next falling edge after rst deasserts. A line still low when rst deasserts is treated as a start.
- No backpressure: the downstream consumer must accept rx_valid when it pulses. Overrun is impossible since frames are at least 10 bit-times apart.

Test Plan:
- CLKS_PER_BIT=16, PARITY_EN=1, drive frame 0xA5 with parity 0 and stop 1 → one rx_valid pulse, rx_data=8'hA5, parity_err=0, frame_err=0, rx_busy low after.
- Byte 0x07 sent with parity bit 0 (wrong; correct is 1) → rx_valid, rx_data=8'h07, parity_err=1, frame_err=0.
- Byte 0x3C with stop bit 0, line held low 40 cycles then high → rx_valid with frame_err=1; state stays WAIT_HIGH until line high; no spurious second frame.
- 4-cycle low glitch on idle rxd → no rx_valid, rx_busy returns 0 within CLKS_PER_BIT/2+3 cycles.
- Three back-to-back frames 0x00, 0xFF, 0x55 with no idle gap → three pulses, data in order, all flags 0.
- rst asserted for 1 cycle during data bit 4 of a frame → no rx_valid for that frame; next full frame 0x81 received correctly.
- Loopback with the team's UART transmitter (CLKS_PER_BIT=1 transmitter and receiver pairing is excluded; transmitter wrapped at 16x bit time) sending 0x12 → rx_data=8'h12.
